// File: rtl/cpu_host_mailbox_if.sv
// Purpose : bundles the CPU strobe bus and the host stream link of cpu_host_mailbox.
// Signals :
//   CPU side  : rd_reg, wr_reg, wr_evt, sel[10:0], tos[15:0] (to mailbox); par[15:0] (from mailbox)
//   Host side : h_wdata, h_wvalid, h_rready, h_irq_ack (to mailbox);
//               h_wready, h_rdata, h_rvalid, h_irq (from mailbox)
// Modports: slave = the mailbox, master = whoever drives the CPU and host sides.
interface cpu_host_mailbox_if;
   logic        rd_reg;
   logic        wr_reg;
   logic        wr_evt;
   logic [10:0] sel;
   logic [15:0] tos;
   logic [15:0] par;
   logic [15:0] h_wdata;
   logic        h_wvalid;
   logic        h_wready;
   logic [15:0] h_rdata;
   logic        h_rvalid;
   logic        h_rready;
   logic        h_irq;
   logic        h_irq_ack;

   modport slave (
      input  rd_reg, wr_reg, wr_evt, sel, tos, h_wdata, h_wvalid, h_rready, h_irq_ack,
      output par, h_wready, h_rdata, h_rvalid, h_irq
   );

   modport master (
      output rd_reg, wr_reg, wr_evt, sel, tos, h_wdata, h_wvalid, h_rready, h_irq_ack,
      input  par, h_wready, h_rdata, h_rvalid, h_irq
   );
endinterface

// File: rtl/cpu_host_mailbox.sv
// Purpose : CPU I/O responder bridging the rdReg/wrReg/wrEvt strobe bus to a host stream link.
//           Host-to-CPU command FIFO (host pushes, CPU pops with GET_CMD), CPU-to-host reply
//           FIFO (CPU pushes with PUT_REPLY, host pops), sticky error flags and a host interrupt.
// Ports   :
//   clk    - system clock
//   rst_n  - synchronous reset, active-low
//   bus    - cpu_host_mailbox_if.slave (CPU strobes/selects/TOS, combinational par,
//            host command push, first-word fall-through reply pop, h_irq / h_irq_ack)
module cpu_host_mailbox #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cpu_host_mailbox_if.slave     bus
);

   localparam int unsigned PW = AW + 1;
   localparam int unsigned DW = 16;

   logic [DW-1:0] r_cmd_mem [DEPTH];
   logic [DW-1:0] r_rep_mem [DEPTH];
   logic [PW-1:0] r_cmd_wp;
   logic [PW-1:0] r_cmd_rp;
   logic [PW-1:0] r_rep_wp;
   logic [PW-1:0] r_rep_rp;
   logic          r_cmd_uf;
   logic          r_rep_ov;
   logic          r_irq;

   logic [PW-1:0] w_cmd_count;
   logic          w_cmd_empty;
   logic          w_cmd_full;
   logic          w_rep_empty;
   logic          w_rep_full;
   logic          w_get_cmd;
   logic          w_get_stat;
   logic          w_put;
   logic          w_done;
   logic          w_flush;
   logic          w_wready;
   logic          w_cmd_push;
   logic          w_cmd_pop;
   logic          w_rep_push;
   logic          w_rep_pop;
   logic [DW-1:0] w_cmd_head;
   logic [DW-1:0] w_status;

   // FIFO state decode: equal pointers = empty, MSB-only difference = full
   assign w_cmd_count = r_cmd_wp - r_cmd_rp;
   assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
   assign w_cmd_full  = (r_cmd_wp[AW] != r_cmd_rp[AW]) &&
                        (r_cmd_wp[AW-1:0] == r_cmd_rp[AW-1:0]);
   assign w_rep_empty = (r_rep_wp == r_rep_rp);
   assign w_rep_full  = (r_rep_wp[AW] != r_rep_rp[AW]) &&
                        (r_rep_wp[AW-1:0] == r_rep_rp[AW-1:0]);

   // Strobe/select decode; unlisted select bits are ignored
   assign w_get_cmd  = bus.rd_reg & bus.sel[0];
   assign w_get_stat = bus.rd_reg & bus.sel[1];
   assign w_put      = bus.wr_reg & bus.sel[0];
   assign w_done     = bus.wr_evt & bus.sel[0];
   assign w_flush    = bus.wr_evt & bus.sel[1];

   // A flush blocks the host push so the emptied FIFO really ends up empty
   assign w_wready   = rst_n & ~w_cmd_full & ~w_flush;
   assign w_cmd_push = bus.h_wvalid & w_wready;
   assign w_cmd_pop  = w_get_cmd & ~w_cmd_empty;
   assign w_rep_push = rst_n & w_put & ~w_rep_full;
   assign w_rep_pop  = ~w_rep_empty & bus.h_rready;

   assign w_cmd_head = w_cmd_empty ? '0 : r_cmd_mem[r_cmd_rp[AW-1:0]];
   assign w_status   = {w_rep_full, w_cmd_empty, r_cmd_uf, r_rep_ov, 4'b0000, 8'(w_cmd_count)};

   // Read data is combinational so the CPU captures it into TOS in the strobe cycle
   assign bus.par      = (w_get_cmd  ? w_cmd_head : '0) |
                         (w_get_stat ? w_status   : '0);
   assign bus.h_wready = w_wready;
   assign bus.h_rdata  = r_rep_mem[r_rep_rp[AW-1:0]];
   assign bus.h_rvalid = ~w_rep_empty;
   assign bus.h_irq    = r_irq;

   // Storage arrays carry no reset; only the pointers define contents
   always_ff @(posedge clk) begin
      if (w_cmd_push) r_cmd_mem[r_cmd_wp[AW-1:0]] <= bus.h_wdata;
      if (w_rep_push) r_rep_mem[r_rep_wp[AW-1:0]] <= bus.tos;
   end

   // Pointers, sticky flags and interrupt
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cmd_wp <= '0;
         r_cmd_rp <= '0;
         r_rep_wp <= '0;
         r_rep_rp <= '0;
         r_cmd_uf <= 1'b0;
         r_rep_ov <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_cmd_push) r_cmd_wp <= r_cmd_wp + PW'(1);
         if (w_flush)
            r_cmd_rp <= r_cmd_wp;
         else if (w_cmd_pop)
            r_cmd_rp <= r_cmd_rp + PW'(1);
         if (w_rep_push) r_rep_wp <= r_rep_wp + PW'(1);
         if (w_rep_pop)  r_rep_rp <= r_rep_rp + PW'(1);
         // A fresh error in the status-read cycle keeps its flag set
         r_cmd_uf <= (w_get_cmd & w_cmd_empty) | (r_cmd_uf & ~w_get_stat);
         r_rep_ov <= (w_put & w_rep_full)      | (r_rep_ov & ~w_get_stat);
         r_irq    <= w_done | (r_irq & ~bus.h_irq_ack);
      end
   end

endmodule
